// File: rtl/regfile_writeback_pkg.sv
// Shared core definitions for the integer register file writeback stage.
// Holds the register geometry (XLEN, REGW, x0 index), the queued result
// record and the writeback source select used by the arbiter.
package regfile_writeback_pkg;

  localparam int XLEN  = 64;
  localparam int REGW  = 5;
  localparam int NREGS = 1 << REGW;

  localparam logic [REGW-1:0] X0_IDX = '0;

  // One queued long-latency result: destination index plus value.
  typedef struct packed {
    logic [REGW-1:0] rd;
    logic [XLEN-1:0] data;
  } wb_entry_t;

  localparam int ENTRY_W = $bits(wb_entry_t);

  typedef enum logic [1:0] {
    SEL_NONE = 2'd0,
    SEL_ALU  = 2'd1,
    SEL_FIFO = 2'd2
  } wb_sel_e;

  // Writes to x0 are architecturally dropped everywhere in this stage.
  function automatic logic is_x0(input logic [REGW-1:0] idx);
    return idx == X0_IDX;
  endfunction

endpackage

// File: rtl/regfile_writeback_if.sv
// Bus bundle between the execute/decode side and the writeback stage.
// Groups the ALU result, the LSU/MUL valid/ready result channel, the
// long-op issue strobe, the decode source lookups and the register file
// write port.
//   master : producer/consumer side (execute units, decode, register file)
//   slave  : the writeback stage itself
interface regfile_writeback_if;
  import regfile_writeback_pkg::*;

  logic            alu_valid;
  logic [REGW-1:0] alu_rd;
  logic [XLEN-1:0] alu_data;

  logic            lsu_valid;
  logic            lsu_ready;
  logic [REGW-1:0] lsu_rd;
  logic [XLEN-1:0] lsu_data;

  logic            iss_valid;
  logic [REGW-1:0] iss_rd;

  logic [REGW-1:0] rs1;
  logic [REGW-1:0] rs2;
  logic            rs1_busy;
  logic            rs2_busy;
  logic            rs1_fwd_vld;
  logic            rs2_fwd_vld;
  logic [XLEN-1:0] rs1_fwd_data;
  logic [XLEN-1:0] rs2_fwd_data;

  logic            wb_en;
  logic [REGW-1:0] wb_rd;
  logic [XLEN-1:0] wb_data;

  modport master (
    output alu_valid, alu_rd, alu_data,
    output lsu_valid, lsu_rd, lsu_data,
    input  lsu_ready,
    output iss_valid, iss_rd,
    output rs1, rs2,
    input  rs1_busy, rs2_busy,
    input  rs1_fwd_vld, rs2_fwd_vld, rs1_fwd_data, rs2_fwd_data,
    input  wb_en, wb_rd, wb_data
  );

  modport slave (
    input  alu_valid, alu_rd, alu_data,
    input  lsu_valid, lsu_rd, lsu_data,
    output lsu_ready,
    input  iss_valid, iss_rd,
    input  rs1, rs2,
    output rs1_busy, rs2_busy,
    output rs1_fwd_vld, rs2_fwd_vld, rs1_fwd_data, rs2_fwd_data,
    output wb_en, wb_rd, wb_data
  );

endinterface

// File: rtl/regfile_writeback_fifo.sv
// wb_result_fifo: small synchronous in-order FIFO for writeback results.
// DEPTH must be a power of two (>= 2) so the pointers wrap naturally.
// Ports:
//   clk, rst   clock and synchronous active-high reset (flushes contents)
//   push       write push_data when not full
//   push_data  entry to enqueue
//   pop        drop the head entry when not empty
//   full       DEPTH entries held
//   empty      no entries held
//   head       oldest entry (valid when !empty)
module wb_result_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic [CW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem[rd_ptr];

  // Storage is not reset; the count alone decides what is valid.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/regfile_writeback.sv
// regfile_writeback: drives the single integer register file write port.
// The never-stalled ALU result has priority; long-latency LSU/MUL results
// arrive over valid/ready, are buffered in wb_result_fifo and drain when the
// ALU is not writing. A pending-write scoreboard lets decode stall on RAW
// hazards, and the registered write is forwarded to same-cycle reads.
// Ports:
//   clk  clock, rising edge
//   rst  synchronous active-high reset
//   bus  slave side of regfile_writeback_if (ALU, LSU channel, issue strobe,
//        decode lookups, register file write port)
module regfile_writeback
  import regfile_writeback_pkg::*;
#(
  parameter int QDEPTH = 2
) (
  input  logic                clk,
  input  logic                rst,
  regfile_writeback_if.slave  bus
);

  wb_entry_t        push_entry;
  logic [ENTRY_W-1:0] head_bits;
  wb_entry_t        head_entry;
  logic             fifo_full;
  logic             fifo_empty;
  logic             fifo_push;
  logic             fifo_pop;
  wb_sel_e          sel;

  logic             wb_en_q;
  logic [REGW-1:0]  wb_rd_q;
  logic [XLEN-1:0]  wb_data_q;

  logic [NREGS-1:0] pending_q;
  logic [NREGS-1:0] set_mask;
  logic [NREGS-1:0] clr_mask;

  // No pass-through: a full FIFO refuses even when it pops this cycle.
  assign bus.lsu_ready = ~rst & ~fifo_full;
  assign fifo_push     = bus.lsu_valid & bus.lsu_ready;
  assign push_entry    = '{rd: bus.lsu_rd, data: bus.lsu_data};
  assign head_entry    = wb_entry_t'(head_bits);

  wb_result_fifo #(
    .DEPTH (QDEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push),
    .push_data (push_entry),
    .pop       (fifo_pop),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .head      (head_bits)
  );

  // An ALU result to x0 does not claim the port, so the FIFO head can drain.
  always_comb begin
    sel = SEL_NONE;
    if (bus.alu_valid && !is_x0(bus.alu_rd)) begin
      sel = SEL_ALU;
    end else if (!fifo_empty) begin
      sel = SEL_FIFO;
    end
  end

  // Queued entries are dropped, not written, while in reset.
  assign fifo_pop = (sel == SEL_FIFO) & ~rst;

  // Index and data hold when nothing writes; only the enable drops.
  always_ff @(posedge clk) begin
    if (rst) begin
      wb_en_q   <= 1'b0;
      wb_rd_q   <= '0;
      wb_data_q <= '0;
    end else begin
      case (sel)
        SEL_ALU: begin
          wb_en_q   <= 1'b1;
          wb_rd_q   <= bus.alu_rd;
          wb_data_q <= bus.alu_data;
        end
        SEL_FIFO: begin
          if (is_x0(head_entry.rd)) begin
            wb_en_q <= 1'b0;
          end else begin
            wb_en_q   <= 1'b1;
            wb_rd_q   <= head_entry.rd;
            wb_data_q <= head_entry.data;
          end
        end
        default: begin
          wb_en_q <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    if (bus.iss_valid && !is_x0(bus.iss_rd)) begin
      set_mask[bus.iss_rd] = 1'b1;
    end
    if (fifo_pop && !is_x0(head_entry.rd)) begin
      clr_mask[head_entry.rd] = 1'b1;
    end
  end

  // OR-ing the set after the clear makes a same-cycle issue win.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending_q <= '0;
    end else begin
      pending_q <= (pending_q & ~clr_mask) | set_mask;
    end
  end

  assign bus.rs1_busy = pending_q[bus.rs1] & ~is_x0(bus.rs1);
  assign bus.rs2_busy = pending_q[bus.rs2] & ~is_x0(bus.rs2);

  assign bus.rs1_fwd_vld  = wb_en_q & (wb_rd_q == bus.rs1) & ~is_x0(bus.rs1);
  assign bus.rs2_fwd_vld  = wb_en_q & (wb_rd_q == bus.rs2) & ~is_x0(bus.rs2);
  assign bus.rs1_fwd_data = wb_data_q;
  assign bus.rs2_fwd_data = wb_data_q;

  assign bus.wb_en   = wb_en_q;
  assign bus.wb_rd   = wb_rd_q;
  assign bus.wb_data = wb_data_q;

endmodule
